// File: rtl/motoro301_top.sv
// rtl/motoro301_top.sv - six-step 120-degree commutation sequencer with dead time
//
// Purpose: turns a requested electrical frequency into a six-step gate pattern
// for a three-phase bridge. Every commutation inserts a 50-clock all-off window.
// Optional feature macro: MOTORO301_UART_EN. It reports each new step index as
// ASCII '0'..'5' on uTx.
//
// Ports:
//   clk50mhz     in   50 MHz system clock
//   nReset       in   synchronous reset, active high
//   m3start      in   run enable (level, asynchronous)
//   m3invOrStop  in   direction, 1 = reverse (asynchronous)
//   m3freq[9:0]  in   electrical frequency in Hz
//   aH..cL       out  high/low-side gate drives, active high
//   tp01         out  one-clock strobe per commutation
//   tp02         out  dead-time window active
//   uTx          out  UART transmit line, idle high
//   led4[3:0]    out  {uart busy, step-0 toggle, reverse, running}
module motoro301_top (
  input  logic       clk50mhz,
  input  logic       nReset,
  input  logic       m3start,
  input  logic       m3invOrStop,
  input  logic [9:0] m3freq,
  output logic       aH,
  output logic       aL,
  output logic       bH,
  output logic       bL,
  output logic       cH,
  output logic       cL,
  output logic       tp01,
  output logic       tp02,
  output logic       uTx,
  output logic [3:0] led4
);

  localparam logic [5:0]  DEAD    = 6'd50;
  localparam logic [26:0] ACC_MOD = 27'd50_000_000;

  logic        start_s1_q, start_s2_q, start_prev_q;
  logic        inv_s1_q, inv_s2_q;
  logic [1:0]  sync_vld_q;
  logic        armed_q, armed_d;
  logic        running_q, running_d;
  logic [25:0] acc_q, acc_d;
  logic [2:0]  step_q, step_d;
  logic [5:0]  dead_q, dead_d;
  logic        tp01_q;
  logic        led2_q, led2_d;

  logic        active, start_rise, step_evt;
  logic [12:0] inc;
  logic [26:0] sum;
  logic        uart_busy;

  // A start edge only counts once the synchronized input has been seen low
  // after reset, so a start held high across reset does not restart the motor.
  assign start_rise = armed_q & start_s2_q & ~start_prev_q;
  assign active     = running_q & start_s2_q;
  assign inc        = {1'b0, m3freq, 2'b00} + {2'b00, m3freq, 1'b0};
  assign sum        = {1'b0, acc_q} + {14'd0, inc};
  assign step_evt   = active & ~start_rise & (m3freq != 10'd0) & (sum >= ACC_MOD);

  always_comb begin
    armed_d   = armed_q | (sync_vld_q[1] & ~start_s2_q);
    running_d = running_q;
    acc_d     = acc_q;
    step_d    = step_q;
    dead_d    = dead_q;
    led2_d    = led2_q;
    if (!start_s2_q) begin
      running_d = 1'b0;
    end else if (start_rise) begin
      running_d = 1'b1;
      acc_d     = 26'd0;
      step_d    = 3'd0;
      dead_d    = DEAD;
    end else if (active) begin
      if (dead_q != 6'd0) begin
        dead_d = dead_q - 6'd1;
      end
      if (m3freq != 10'd0) begin
        if (step_evt) begin
          acc_d  = sum[25:0] - ACC_MOD[25:0];
          dead_d = DEAD;
          if (inv_s2_q) begin
            step_d = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
          end else begin
            step_d = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
          end
          if (step_d == 3'd0) begin
            led2_d = ~led2_q;
          end
        end else begin
          acc_d = sum[25:0];
        end
      end
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (nReset) begin
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_prev_q <= 1'b0;
      inv_s1_q     <= 1'b0;
      inv_s2_q     <= 1'b0;
      sync_vld_q   <= 2'b00;
      armed_q      <= 1'b0;
      running_q    <= 1'b0;
      acc_q        <= 26'd0;
      step_q       <= 3'd0;
      dead_q       <= 6'd0;
      tp01_q       <= 1'b0;
      led2_q       <= 1'b0;
    end else begin
      start_s1_q   <= m3start;
      start_s2_q   <= start_s1_q;
      start_prev_q <= start_s2_q;
      inv_s1_q     <= m3invOrStop;
      inv_s2_q     <= inv_s1_q;
      sync_vld_q   <= {sync_vld_q[0], 1'b1};
      armed_q      <= armed_d;
      running_q    <= running_d;
      acc_q        <= acc_d;
      step_q       <= step_d;
      dead_q       <= dead_d;
      tp01_q       <= step_evt;
      led2_q       <= led2_d;
    end
  end

  // Gate outputs are decoded from registered state and qualified by the
  // synchronized start, so dropping start blanks the bridge immediately.
  always_comb begin
    {aH, aL, bH, bL, cH, cL} = 6'b000000;
    if (active && dead_q == 6'd0) begin
      case (step_q)
        3'd0:    {aH, bL} = 2'b11;
        3'd1:    {aH, cL} = 2'b11;
        3'd2:    {bH, cL} = 2'b11;
        3'd3:    {bH, aL} = 2'b11;
        3'd4:    {cH, aL} = 2'b11;
        3'd5:    {cH, bL} = 2'b11;
        default: {aH, aL, bH, bL, cH, cL} = 6'b000000;
      endcase
    end
  end

  assign tp01 = tp01_q;
  assign tp02 = active & (dead_q != 6'd0);
  assign led4 = {uart_busy, led2_q, inv_s2_q, running_q};

`ifdef MOTORO301_UART_EN
  localparam logic [8:0] BAUD_LAST = 9'd433;

  logic       tx_busy_q;
  logic [8:0] tx_baud_q;
  logic [3:0] tx_bit_q;
  logic [9:0] tx_shift_q;

  // Frame is {stop, data, start}, shifted out LSB first; ones fill behind it.
  always_ff @(posedge clk50mhz) begin
    if (nReset) begin
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= 9'd0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= 10'h3FF;
    end else if (!tx_busy_q && step_evt) begin
      tx_busy_q  <= 1'b1;
      tx_baud_q  <= 9'd0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= {1'b1, 8'h30 + {5'd0, step_d}, 1'b0};
    end else if (tx_busy_q) begin
      if (tx_baud_q == BAUD_LAST) begin
        tx_baud_q <= 9'd0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q  <= 1'b0;
          tx_shift_q <= 10'h3FF;
        end else begin
          tx_bit_q   <= tx_bit_q + 4'd1;
          tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        end
      end else begin
        tx_baud_q <= tx_baud_q + 9'd1;
      end
    end
  end

  assign uTx       = tx_shift_q[0];
  assign uart_busy = tx_busy_q;
`else
  assign uTx       = 1'b1;
  assign uart_busy = 1'b0;
`endif

endmodule

// File: tb/tb_motoro301_top.sv
// tb/tb_motoro301_top.sv - self-checking bench for motoro301_top
module tb_motoro301_top;

  logic       clk50mhz = 1'b0;
  logic       nReset = 1'b1;
  logic       m3start = 1'b0;
  logic       m3invOrStop = 1'b0;
  logic [9:0] m3freq = 10'd0;
  logic       aH, aL, bH, bL, cH, cL, tp01, tp02, uTx;
  logic [3:0] led4;

  int checks = 0;
  int failures = 0;
  bit led2_m = 1'b0;

  motoro301_top dut (
    .clk50mhz   (clk50mhz),
    .nReset     (nReset),
    .m3start    (m3start),
    .m3invOrStop(m3invOrStop),
    .m3freq     (m3freq),
    .aH         (aH),
    .aL         (aL),
    .bH         (bH),
    .bL         (bL),
    .cH         (cH),
    .cL         (cL),
    .tp01       (tp01),
    .tp02       (tp02),
    .uTx        (uTx),
    .led4       (led4)
  );

  always #10 clk50mhz = ~clk50mhz;

  wire [5:0] gates = {aH, aL, bH, bL, cH, cL};

  typedef struct {
    bit         rst;
    bit         st;
    bit         inv;
    logic [9:0] f;
    int         wait_n;
    logic [5:0] g;
    bit         t2;
    logic [1:0] led;
  } vec_t;

  vec_t tbl[8];

  // Bit order {aH,aL,bH,bL,cH,cL}
  function automatic logic [5:0] pat(int s);
    case (s)
      0: return 6'b100100;
      1: return 6'b100001;
      2: return 6'b001001;
      3: return 6'b011000;
      4: return 6'b010010;
      5: return 6'b000110;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk50mhz);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_overlap(string name);
    check(name, {29'd0, aH & aL, bH & bL, cH & cL}, 32'd0);
  endtask

  // Step count after n running clocks is floor(n*6f/50M); each event happened
  // at the first clock whose cumulative phase reached the next multiple of 50M.
  task automatic run_model(bit inv, int f, int ncyc);
    longint k, e, rate;
    int     s;
    logic [5:0] eg;
    bit     et1, et2;
    m3start = 1'b0;
    m3invOrStop = inv;
    m3freq = 10'(f);
    tick(4);
    m3start = 1'b1;
    tick(3);
    rate = 6 * longint'(f);
    k = 0;
    for (int n = 0; n <= ncyc; n++) begin
      if (n > 0) tick(1);
      k = (longint'(n) * rate) / 64'd50_000_000;
      e = (k == 0) ? 0 : (k * 64'd50_000_000 + rate - 1) / rate;
      s = inv ? int'((6 - (k % 6)) % 6) : int'(k % 6);
      et1 = (k > 0) && (e == longint'(n));
      et2 = (longint'(n) - e) < 50;
      eg = et2 ? 6'b000000 : pat(s);
      check($sformatf("run_f%0d_inv%0d_n%0d", f, inv, n),
            {21'd0, gates, tp01, tp02, led4[2:0]},
            {21'd0, eg, et1, et2, led2_m ^ bit'((k / 6) & 1), inv, 1'b1});
      check_overlap("overlap");
`ifndef MOTORO301_UART_EN
      check("uart_idle", {30'd0, uTx, led4[3]}, 32'b10);
`endif
    end
    led2_m = led2_m ^ bit'((k / 6) & 1);
  endtask

  initial begin
    tbl[0] = '{rst:1, st:0, inv:0, f:10'd100, wait_n:2,  g:6'b000000, t2:0, led:2'b00};
    tbl[1] = '{rst:0, st:0, inv:0, f:10'd100, wait_n:3,  g:6'b000000, t2:0, led:2'b00};
    tbl[2] = '{rst:0, st:1, inv:0, f:10'd100, wait_n:52, g:6'b000000, t2:1, led:2'b01};
    tbl[3] = '{rst:0, st:1, inv:0, f:10'd100, wait_n:1,  g:6'b100100, t2:0, led:2'b01};
    tbl[4] = '{rst:0, st:0, inv:0, f:10'd100, wait_n:3,  g:6'b000000, t2:0, led:2'b00};
    tbl[5] = '{rst:0, st:1, inv:1, f:10'd100, wait_n:53, g:6'b100100, t2:0, led:2'b11};
    tbl[6] = '{rst:1, st:1, inv:1, f:10'd100, wait_n:1,  g:6'b000000, t2:0, led:2'b00};
    tbl[7] = '{rst:0, st:1, inv:1, f:10'd100, wait_n:100, g:6'b000000, t2:0, led:2'b10};

    tick(1);
    for (int i = 0; i < 8; i++) begin
      nReset = tbl[i].rst;
      m3start = tbl[i].st;
      m3invOrStop = tbl[i].inv;
      m3freq = tbl[i].f;
      tick(tbl[i].wait_n);
      check($sformatf("vec%0d_gates", i), {26'd0, gates}, {26'd0, tbl[i].g});
      check($sformatf("vec%0d_tp", i), {30'd0, tp01, tp02}, {30'd0, 1'b0, tbl[i].t2});
      check($sformatf("vec%0d_led", i), {28'd0, led4}, {28'd0, 2'b00, tbl[i].led});
      check($sformatf("vec%0d_utx", i), {31'd0, uTx}, 32'd1);
    end

    run_model(1'b0, int'($urandom_range(950, 1023)), 20000);
    run_model(1'b1, int'($urandom_range(950, 1023)), 20000);
    run_model(1'b0, 0, 5000);

    // Reset while running at speed
    run_model(1'b0, 1023, 300);
    nReset = 1'b1;
    tick(1);
    check("midrun_reset_gates", {26'd0, gates}, 32'd0);
    check("midrun_reset_dbg", {25'd0, tp01, tp02, uTx, led4}, {25'd0, 3'b001, 4'b0000});
    led2_m = 1'b0;
    nReset = 1'b0;
    m3start = 1'b0;
    tick(3);

`ifdef MOTORO301_UART_EN
    begin
      int  guard;
      bit  seen;
      logic [9:0] frame;
      frame = {1'b1, 8'h31, 1'b0};
      tick(5000);
      m3freq = 10'd1023;
      m3invOrStop = 1'b0;
      m3start = 1'b1;
      seen = 1'b0;
      guard = 0;
      while (!seen && guard < 20000) begin
        tick(1);
        guard++;
        if (tp01) seen = 1'b1;
      end
      check("uart_step_seen", {31'd0, seen}, 32'd1);
      if (seen) begin
        int off;
        off = 0;
        for (int b = 0; b < 10; b++) begin
          tick(b * 434 + 217 - off);
          off = b * 434 + 217;
          check($sformatf("uart_bit%0d", b), {31'd0, uTx}, {31'd0, frame[b]});
        end
        tick(4339 - off);
        check("uart_busy_last", {31'd0, led4[3]}, 32'd1);
        tick(1);
        check("uart_busy_clear", {31'd0, led4[3]}, 32'd0);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motoro301_top.md
MOTORO301_TOP -- requirements
Module: motoro301_top

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk50mhz in 1, 50 MHz system clock; nReset in 1, synchronous active-high reset (asserted when 1, sampled on clk50mhz rising edge).
REQ-002 SHALL have these ports: m3start in 1, run enable (level).
- m3invOrStop in 1, direction select (1 = reverse).
- m3freq in 10, electrical frequency in Hz, 0..1023.
REQ-003 SHALL have gate outputs aH, aL, bH, bL, cH, cL out 1 each: high/low-side gate drives of phases A/B/C, active-high.
REQ-004 SHALL have these debug outputs:
- tp01 out 1, one-clock commutation strobe.
- tp02 out 1, dead-time active.
- uTx out 1, UART transmit line, idle high.
- led4 out 4, status.

Function
REQ-005 SHALL pass m3start and m3invOrStop through 2-flop synchronizers; all logic uses the synchronized copies (2-clock input latency).
REQ-006 SHALL keep a 26-bit phase accumulator: each clock while running, acc += 6*m3freq; when the sum is >= 50_000_000, subtract 50_000_000 and raise a step event (exact average step rate 6*m3freq per second).
REQ-007 SHALL hold the step and accumulator when m3freq = 0; no step events.
REQ-008 SHALL keep a step index 0..5; on a step event it increments (wrap 5->0) when forward and decrements (wrap 0->5) when reverse.
REQ-009 SHALL use this six-step 120-degree table (high-side/low-side on):
- step 0 = aH/bL; step 1 = aH/cL; step 2 = bH/cL.
- step 3 = bH/aL; step 4 = cH/aL; step 5 = cH/bL.
- All other gate outputs 0.
REQ-010 SHALL, on every step event, drive all six gates 0 for DEAD = 50 clocks (1 us), then apply the new step pattern; tp02 = 1 during this window.
REQ-011 SHALL never assert xH and xL of the same phase in the same clock, under any input sequence.
REQ-012 SHALL, on a synchronized m3start rising edge:
- Clear the accumulator and set the step to 0.
- Run a 50-clock dead time, then drive step 0.
REQ-013 SHALL, when synchronized m3start = 0, drive all gates 0 within 1 clock of the synchronized input; step and accumulator freeze.
REQ-014 SHALL, on a direction change while running, apply the new direction at the next step event; it causes no extra dead time.
REQ-015 SHALL pulse tp01 high for exactly 1 clock on each step event.
REQ-016 SHALL drive led4 as follows:
- led4[0] = running.
- led4[1] = reverse.
- led4[2] toggles each time step 0 is entered while running.
- led4[3] = UART busy.

Reset
REQ-017 SHALL, while nReset = 1:
- Drive all gates 0, tp01 = 0, tp02 = 0, uTx = 1, led4 = 0.
- Clear step, accumulator, dead-time counter, synchronizers and UART.
REQ-018 SHALL, on reset asserted mid-run, take effect at the next clock edge; after release the block stays idle until a fresh m3start rising edge.

Configuration
REQ-019 SHALL support macro MOTORO301_UART_EN. When defined:
- On each step event, if the UART is idle, send one byte 0x30 + new step index.
- Format: 115200 baud (434 clocks/bit), 8N1, LSB first.
- If the UART is busy, the byte is dropped.
REQ-020 SHALL, when MOTORO301_UART_EN is not defined, hold uTx = 1 and led4[3] = 0; the UART logic is absent.

Verification
REQ-021 SHALL verify start at 100 Hz: reset pulse, m3freq = 100, m3start 0->1 -> aH = bL = 1 after 2+1+50 clocks; step events every 83333/83334 clocks; 600 steps per second average.
REQ-022 SHALL verify dead time: at every tp01 pulse -> all gates 0 for exactly 50 clocks, tp02 = 1 for those clocks; no xH&xL overlap over 12 ms.
REQ-023 SHALL verify reverse: m3invOrStop = 1, m3freq = 200 -> step order 0,5,4,3,2,1 (cH/bL follows aH/bL); led4[1] = 1.
REQ-024 SHALL verify stop and reset: m3start 1->0 -> all gates 0 by 3 clocks; nReset = 1 mid-run -> outputs at reset values next clock; m3freq = 0 -> no tp01 for 1 ms.
REQ-025 SHALL verify UART (MOTORO301_UART_EN defined): entry to step 1 -> uTx frame start bit, data 0x31 LSB first, stop bit, 434 clocks per bit; led4[3] high for 4340 clocks.
